// File: rtl/downsampler2.sv
// 2x2 spatial downsampler: NUMCOL x NUMROW raster in, NUMCOL/2 x NUMROW/2 out.
// Define DOWNSAMPLE_AVG_EN for 2x2 rounded averaging; otherwise even/even pixels are decimated.
module downsampler2 #(
    parameter int NUMCOL = 800,
    parameter int NUMROW = 600,
    parameter int CW     = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid,
    input  logic          sof,
    input  logic [7:0]    data,
    output logic [CW-1:0] current_rowcount,
    output logic [CW-1:0] current_colcount,
    output logic [7:0]    dataout,
    output logic          validout,
    output logic          frame_done,
    output logic          sync_err
);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] pix_col, pix_row;
    logic          last_col, last_row;
    logic          out_fire, last_blk;
    logic [7:0]    pix_out;
    logic [7:0]    dataout_q;
    logic          validout_q, frame_done_q, sync_err_q;

    // A qualified sof forces the current pixel to (0,0) regardless of the counters.
    always_comb begin
        pix_col  = sof ? '0 : col_q;
        pix_row  = sof ? '0 : row_q;
        last_col = (pix_col == CW'(NUMCOL - 1));
        last_row = (pix_row == CW'(NUMROW - 1));
        col_d    = col_q;
        row_d    = row_q;
        if (valid) begin
            col_d = last_col ? '0 : pix_col + CW'(1);
            if (last_col) begin
                row_d = last_row ? '0 : pix_row + CW'(1);
            end else begin
                row_d = pix_row;
            end
        end
    end

`ifdef DOWNSAMPLE_AVG_EN
    localparam int AW = $clog2(NUMCOL / 2);

    logic [7:0]    hold_q;
    logic [8:0]    rd_q;
    logic [8:0]    hsum;
    logic [9:0]    total;
    logic [AW-1:0] lb_idx;
    logic [8:0]    linebuf [NUMCOL/2];

    assign hsum     = {1'b0, hold_q} + {1'b0, data};
    assign total    = {1'b0, rd_q} + {1'b0, hsum};
    assign lb_idx   = AW'(pix_col >> 1);
    assign out_fire = valid && pix_row[0] && pix_col[0];
    assign last_blk = last_row && last_col;
    assign pix_out  = 8'((total + 10'd2) >> 2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (valid && !pix_col[0]) begin
            hold_q <= data;
        end
    end

    // Even rows fill the buffer; odd rows prefetch on the even-column beat so the
    // odd-column beat can produce its result one cycle later even across gaps.
    always_ff @(posedge clock) begin
        if (valid && !pix_row[0] && pix_col[0]) begin
            linebuf[lb_idx] <= hsum;
        end
        if (valid && pix_row[0] && !pix_col[0]) begin
            rd_q <= linebuf[lb_idx];
        end
    end
`else
    assign out_fire = valid && !pix_row[0] && !pix_col[0];
    assign last_blk = (pix_row == CW'(NUMROW - 2)) && (pix_col == CW'(NUMCOL - 2));
    assign pix_out  = data;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            dataout_q    <= '0;
            validout_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            validout_q   <= out_fire;
            frame_done_q <= out_fire && last_blk;
            sync_err_q   <= valid && sof && ((col_q != '0) || (row_q != '0));
            if (out_fire) begin
                dataout_q <= pix_out;
            end
        end
    end

    assign current_rowcount = row_q;
    assign current_colcount = col_q;
    assign dataout          = dataout_q;
    assign validout         = validout_q;
    assign frame_done       = frame_done_q;
    assign sync_err         = sync_err_q;

endmodule

// File: tb/tb_downsampler2.sv
// Directed bench for downsampler2 on a reduced 8x6 frame; expectations come from a frame-image model.
module tb_downsampler2;
    localparam int NC = 8;
    localparam int NR = 6;
    localparam int W  = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         valid = 1'b0;
    logic         sof   = 1'b0;
    logic [7:0]   data  = 8'h00;
    logic [W-1:0] current_rowcount;
    logic [W-1:0] current_colcount;
    logic [7:0]   dataout;
    logic         validout;
    logic         frame_done;
    logic         sync_err;

    int compared   = 0;
    int mismatched = 0;
    int m_row = 0;
    int m_col = 0;
    int img [NR][NC];
    int outs [$];

    always #5 clock = ~clock;

    downsampler2 #(.NUMCOL(NC), .NUMROW(NR), .CW(W)) dut (
        .clock            (clock),
        .reset            (reset),
        .valid            (valid),
        .sof              (sof),
        .data             (data),
        .current_rowcount (current_rowcount),
        .current_colcount (current_colcount),
        .dataout          (dataout),
        .validout         (validout),
        .frame_done       (frame_done),
        .sync_err         (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
        check("rowcount", 32'(current_rowcount), m_row);
        check("colcount", 32'(current_colcount), m_col);
    endtask

    // One accepted pixel; checks the registered outputs 1 time unit after the edge.
    task automatic push(input int d, input bit s, output bit fired);
        int pr, pc, ev, ed, efd, ese;
        @(negedge clock);
        valid = 1'b1;
        sof   = s;
        data  = 8'(d);
        pr  = s ? 0 : m_row;
        pc  = s ? 0 : m_col;
        ese = (s && (m_row != 0 || m_col != 0)) ? 1 : 0;
        img[pr][pc] = d;
`ifdef DOWNSAMPLE_AVG_EN
        ev  = (pr % 2 == 1 && pc % 2 == 1) ? 1 : 0;
        ed  = ev ? (img[pr-1][pc-1] + img[pr-1][pc] + img[pr][pc-1] + img[pr][pc] + 2) / 4 : 0;
        efd = (ev && pr == NR - 1 && pc == NC - 1) ? 1 : 0;
`else
        ev  = (pr % 2 == 0 && pc % 2 == 0) ? 1 : 0;
        ed  = d;
        efd = (ev && pr == NR - 2 && pc == NC - 2) ? 1 : 0;
`endif
        m_row = pr;
        m_col = pc + 1;
        if (m_col == NC) begin
            m_col = 0;
            m_row = (pr == NR - 1) ? 0 : pr + 1;
        end
        @(posedge clock);
        #1;
        check("validout", 32'(validout), ev);
        if (ev != 0) begin
            check("dataout", 32'(dataout), ed);
            outs.push_back(int'(dataout));
        end
        check("frame_done", 32'(frame_done), efd);
        check("sync_err", 32'(sync_err), ese);
        check_counters();
        valid = 1'b0;
        sof   = 1'b0;
        fired = (ev != 0);
    endtask

    task automatic idle(input bit s);
        @(negedge clock);
        valid = 1'b0;
        sof   = s;
        data  = 8'hAA;
        @(posedge clock);
        #1;
        check("idle_validout", 32'(validout), 0);
        check("idle_frame_done", 32'(frame_done), 0);
        check("idle_sync_err", 32'(sync_err), 0);
        check_counters();
        sof = 1'b0;
    endtask

    // kind 0 = flat 0x64, otherwise a ramp-like pattern; random idle gaps up to gapmax.
    task automatic frame(input int kind, input int gapmax);
        bit f;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                push((kind == 0) ? 'h64 : ((r * 3 + c * 5 + kind) & 255), (r == 0 && c == 0), f);
                if (gapmax > 0) begin
                    repeat ($urandom_range(0, gapmax)) idle(1'b0);
                end
            end
        end
    endtask

    initial begin
        int row0 [NC];
        int row1 [NC];
        int exp4 [4];
        bit f;
        int guard;

        // Reset state
        #12;
        check("rst_dataout", 32'(dataout), 0);
        check("rst_validout", 32'(validout), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        check_counters();
        @(negedge clock);
        reset = 1'b1;
        idle(1'b0);

        // Flat frame, continuous valid
        outs.delete();
        frame(0, 0);
        check("flat_count", outs.size(), NR * NC / 4);
        foreach (outs[i]) check("flat_value", outs[i], 'h64);

        // Rounding blocks in the top two rows
        row0 = '{0, 0, 1, 1, 0, 1, 255, 255};
        row1 = '{0, 1, 1, 0, 1, 0, 255, 255};
`ifdef DOWNSAMPLE_AVG_EN
        exp4 = '{0, 1, 1, 255};
`else
        exp4 = '{0, 1, 0, 255};
`endif
        outs.delete();
        for (int c = 0; c < NC; c++) push(row0[c], (c == 0), f);
        for (int c = 0; c < NC; c++) push(row1[c], 1'b0, f);
        for (int i = 0; i < (NR - 2) * NC; i++) push(0, 1'b0, f);
        check("round_count", outs.size(), NR * NC / 4);
        for (int i = 0; i < 4; i++) check("round_value", outs[i], exp4[i]);

        // Gappy ramp frame; sof without valid must be ignored
        frame(7, 2);
        push(9, 1'b1, f);
        push(10, 1'b0, f);
        idle(1'b1);
        push(11, 1'b0, f);

        // Mid-frame resync at (3,5), then a full new frame
        for (int i = 0; i < 3 * NC + 5 - 3; i++) push(i & 255, 1'b0, f);
        check("resync_row", m_row, 3);
        check("resync_col", m_col, 5);
        frame(13, 1);

        // Asynchronous reset right after an output strobe, mid-row
        guard = 0;
        push(200, 1'b1, f);
        while (!f && guard < 4 * NC) begin
            push(201 + guard, 1'b0, f);
            guard++;
        end
        check("pre_reset_validout", 32'(validout), 1);
        #2;
        reset = 1'b0;
        #1;
        m_row = 0;
        m_col = 0;
        check("async_dataout", 32'(dataout), 0);
        check("async_validout", 32'(validout), 0);
        check("async_frame_done", 32'(frame_done), 0);
        check("async_sync_err", 32'(sync_err), 0);
        check_counters();
        @(negedge clock);
        reset = 1'b1;
        outs.delete();
        frame(21, 1);
        check("post_reset_count", outs.size(), NR * NC / 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
